// File: rtl/commit_trace_buffer.sv
// Retirement trace buffer: captures up to two retired instructions plus a trap record per
// cycle into a 2-write/1-read FIFO and replays them one per cycle on a valid/ready port.
module commit_trace_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned SEQ_W = 16,
    parameter int unsigned VLEN  = 64,
    parameter int unsigned XLEN  = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [1:0]                 commit_ack_i,
    input  logic [1:0][VLEN-1:0]       pc_i,
    input  logic [1:0][4:0]            waddr_i,
    input  logic [1:0][XLEN-1:0]       wdata_i,
    input  logic [1:0]                 we_gpr_i,
    input  logic [1:0]                 we_fpr_i,
    input  logic                       ex_valid_i,
    input  logic [XLEN-1:0]            ex_cause_i,
    input  logic [VLEN-1:0]            ex_pc_i,
    input  logic                       clear_ovf_i,
    output logic                       trace_valid_o,
    input  logic                       trace_ready_i,
    output logic [VLEN-1:0]            trace_pc_o,
    output logic [4:0]                 trace_rd_o,
    output logic [XLEN-1:0]            trace_wdata_o,
    output logic                       trace_we_gpr_o,
    output logic                       trace_we_fpr_o,
    output logic                       trace_ex_o,
    output logic [SEQ_W-1:0]           trace_seq_o,
    output logic                       almost_full_o,
    output logic                       overflow_o,
    output logic [15:0]                drop_cnt_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [VLEN-1:0]  pc;
        logic [4:0]       rd;
        logic [XLEN-1:0]  wdata;
        logic             we_gpr;
        logic             we_fpr;
        logic             ex;
        logic [SEQ_W-1:0] seq;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [SEQ_W-1:0] r_seq;
    logic [15:0]      r_drop_cnt;
    logic             r_overflow;

    entry_t           w_port0, w_port1, w_trap, w_cand0, w_cand1, w_head;
    logic [1:0]       w_nreq, w_ncand, w_npush, w_ndrop;
    logic [CNT_W-1:0] w_free;
    logic             w_pop;
    logic [15:0]      w_drop_base;
    logic [16:0]      w_drop_sum;
    logic [15:0]      w_drop_next;

    // Build the in-order request list and decide how many requests fit.
    always_comb begin
        w_port0 = '{pc: pc_i[0], rd: waddr_i[0], wdata: wdata_i[0], we_gpr: we_gpr_i[0],
                    we_fpr: we_fpr_i[0], ex: 1'b0, seq: r_seq};
        w_port1 = '{pc: pc_i[1], rd: waddr_i[1], wdata: wdata_i[1], we_gpr: we_gpr_i[1],
                    we_fpr: we_fpr_i[1], ex: 1'b0, seq: r_seq};
        w_trap  = '{pc: ex_pc_i, rd: 5'd0, wdata: ex_cause_i, we_gpr: 1'b0,
                    we_fpr: 1'b0, ex: 1'b1, seq: r_seq};
        case (commit_ack_i)
            2'b01:   begin w_cand0 = w_port0; w_cand1 = w_trap;  end
            2'b10:   begin w_cand0 = w_port1; w_cand1 = w_trap;  end
            2'b11:   begin w_cand0 = w_port0; w_cand1 = w_port1; end
            default: begin w_cand0 = w_trap;  w_cand1 = w_trap;  end
        endcase
        w_cand0.seq = r_seq;
        w_cand1.seq = r_seq + SEQ_W'(1);

        w_nreq  = {1'b0, commit_ack_i[0]} + {1'b0, commit_ack_i[1]} + {1'b0, ex_valid_i};
        w_ncand = (w_nreq > 2'd2) ? 2'd2 : w_nreq;
        // Free space is from registered count only: a same-cycle pop does not make room.
        w_free  = CNT_W'(DEPTH) - r_count;
        if ({{(CNT_W-2){1'b0}}, w_ncand} <= w_free) begin
            w_npush = w_ncand;
        end else begin
            w_npush = w_free[1:0];
        end
        w_ndrop = w_nreq - w_npush;
        w_pop   = (r_count != '0) && trace_ready_i;

        w_drop_base = clear_ovf_i ? 16'd0 : r_drop_cnt;
        w_drop_sum  = {1'b0, w_drop_base} + {15'd0, w_ndrop};
        w_drop_next = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    // Queue bookkeeping, sequence numbering and drop accounting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_seq      <= '0;
            r_drop_cnt <= 16'd0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + PTR_W'(w_npush);
            r_rd_ptr   <= r_rd_ptr + PTR_W'(w_pop);
            r_count    <= r_count + CNT_W'(w_npush) - CNT_W'(w_pop);
            r_seq      <= r_seq + SEQ_W'(w_nreq);
            r_drop_cnt <= w_drop_next;
            r_overflow <= (r_overflow && !clear_ovf_i) || (w_ndrop != 2'd0);
        end
    end

    // Entry storage; deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (w_npush != 2'd0)) begin
            r_mem[r_wr_ptr] <= w_cand0;
        end
        if (!rst_i && (w_npush == 2'd2)) begin
            r_mem[r_wr_ptr + PTR_W'(1)] <= w_cand1;
        end
    end

    // Head presentation, zeroed while the queue is empty.
    always_comb begin
        w_head         = r_mem[r_rd_ptr];
        trace_valid_o  = (r_count != '0);
        trace_pc_o     = '0;
        trace_rd_o     = 5'd0;
        trace_wdata_o  = '0;
        trace_we_gpr_o = 1'b0;
        trace_we_fpr_o = 1'b0;
        trace_ex_o     = 1'b0;
        trace_seq_o    = '0;
        if (trace_valid_o) begin
            trace_pc_o     = w_head.pc;
            trace_rd_o     = w_head.rd;
            trace_wdata_o  = w_head.wdata;
            trace_we_gpr_o = w_head.we_gpr;
            trace_we_fpr_o = w_head.we_fpr;
            trace_ex_o     = w_head.ex;
            trace_seq_o    = w_head.seq;
        end else begin
            trace_seq_o    = '0;
        end
        almost_full_o = (w_free < CNT_W'(2));
        overflow_o    = r_overflow;
        drop_cnt_o    = r_drop_cnt;
    end
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_commit_trace_buffer;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst, clr, ready, exv;
    logic [1:0]       ack, gpr, fpr;
    logic [1:0][63:0] pc, wdata;
    logic [1:0][4:0]  waddr;
    logic [63:0]      cause, expc;

    logic        trace_valid_o, trace_we_gpr_o, trace_we_fpr_o, trace_ex_o;
    logic        almost_full_o, overflow_o;
    logic [63:0] trace_pc_o, trace_wdata_o;
    logic [4:0]  trace_rd_o;
    logic [15:0] trace_seq_o, drop_cnt_o;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(16), .VLEN(64), .XLEN(64)) dut (
        .clk_i(clk), .rst_i(rst), .commit_ack_i(ack), .pc_i(pc), .waddr_i(waddr),
        .wdata_i(wdata), .we_gpr_i(gpr), .we_fpr_i(fpr), .ex_valid_i(exv),
        .ex_cause_i(cause), .ex_pc_i(expc), .clear_ovf_i(clr),
        .trace_valid_o(trace_valid_o), .trace_ready_i(ready), .trace_pc_o(trace_pc_o),
        .trace_rd_o(trace_rd_o), .trace_wdata_o(trace_wdata_o),
        .trace_we_gpr_o(trace_we_gpr_o), .trace_we_fpr_o(trace_we_fpr_o),
        .trace_ex_o(trace_ex_o), .trace_seq_o(trace_seq_o),
        .almost_full_o(almost_full_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [63:0] wdata;
        logic        gpr;
        logic        fpr;
        logic        ex;
        logic [15:0] seq;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] mseq;
    int          mdrop;
    logic        movf;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Reference: a plain list of requests, cut to what fits, the rest counted as drops.
    task automatic model_update();
        ent_t reqs[$];
        ent_t e;
        int   nstore, free, drops;
        if (rst) begin
            mq.delete(); mseq = 16'd0; mdrop = 0; movf = 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (ack[p]) begin
                    e = '{pc: pc[p], rd: waddr[p], wdata: wdata[p], gpr: gpr[p],
                          fpr: fpr[p], ex: 1'b0, seq: 16'd0};
                    reqs.push_back(e);
                end
            end
            if (exv) begin
                e = '{pc: expc, rd: 5'd0, wdata: cause, gpr: 1'b0, fpr: 1'b0,
                      ex: 1'b1, seq: 16'd0};
                reqs.push_back(e);
            end
            foreach (reqs[k]) reqs[k].seq = mseq + 16'(k);
            free   = DEPTH - mq.size();
            nstore = (reqs.size() < 2) ? reqs.size() : 2;
            if (nstore > free) nstore = free;
            drops = reqs.size() - nstore;
            if (mq.size() != 0 && ready) void'(mq.pop_front());
            for (int k = 0; k < nstore; k++) mq.push_back(reqs[k]);
            mseq = mseq + 16'(reqs.size());
            if (clr) begin mdrop = 0; movf = 1'b0; end
            mdrop = mdrop + drops;
            if (mdrop > 65535) mdrop = 65535;
            if (drops > 0) movf = 1'b1;
        end
    endtask

    task automatic check_model();
        ent_t h;
        h = (mq.size() != 0) ? mq[0] : '0;
        chk("valid", 64'(trace_valid_o), 64'(mq.size() != 0));
        chk("pc", trace_pc_o, h.pc);
        chk("rd", 64'(trace_rd_o), 64'(h.rd));
        chk("wdata", trace_wdata_o, h.wdata);
        chk("we", 64'({trace_we_gpr_o, trace_we_fpr_o}), 64'({h.gpr, h.fpr}));
        chk("ex", 64'(trace_ex_o), 64'(h.ex));
        chk("seq", 64'(trace_seq_o), 64'(h.seq));
        chk("almost_full", 64'(almost_full_o), 64'((DEPTH - mq.size()) < 2));
        chk("overflow", 64'(overflow_o), 64'(movf));
        chk("drop_cnt", 64'(drop_cnt_o), 64'(mdrop));
    endtask

    task automatic cycle();
        model_update();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic idle();
        rst = 1'b0; clr = 1'b0; ready = 1'b0; exv = 1'b0; ack = 2'b00;
        gpr = 2'b00; fpr = 2'b00; pc = '0; wdata = '0; waddr = '0;
        cause = 64'd0; expc = 64'd0;
    endtask

    task automatic push(input logic [1:0] a, input logic r);
        ack = a; ready = r;
        pc[0] = {$urandom, $urandom}; pc[1] = {$urandom, $urandom};
        waddr[0] = 5'($urandom); waddr[1] = 5'($urandom);
        wdata[0] = {$urandom, $urandom}; wdata[1] = {$urandom, $urandom};
        gpr = 2'($urandom); fpr = 2'($urandom);
        cycle();
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  ack;
        logic [63:0] pc0;
        logic [63:0] pc1;
        logic        ready;
        logic        exp_valid;
        logic [63:0] exp_pc;
        logic [15:0] exp_seq;
        logic        exp_af;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{1'b1, 2'b00, 64'h0,        64'h0,   1'b0, 1'b0, 64'h0,        16'd0, 1'b0};
        tbl[1] = '{1'b0, 2'b01, 64'h80000000, 64'h0,   1'b0, 1'b1, 64'h80000000, 16'd0, 1'b0};
        tbl[2] = '{1'b0, 2'b00, 64'h0,        64'h0,   1'b1, 1'b0, 64'h0,        16'd0, 1'b0};
        tbl[3] = '{1'b1, 2'b00, 64'h0,        64'h0,   1'b0, 1'b0, 64'h0,        16'd0, 1'b0};
        tbl[4] = '{1'b0, 2'b11, 64'h100,      64'h104, 1'b0, 1'b1, 64'h100,      16'd0, 1'b0};
        tbl[5] = '{1'b0, 2'b00, 64'h0,        64'h0,   1'b1, 1'b1, 64'h104,      16'd1, 1'b0};
        tbl[6] = '{1'b0, 2'b00, 64'h0,        64'h0,   1'b1, 1'b0, 64'h0,        16'd0, 1'b0};

        idle();
        foreach (tbl[i]) begin
            idle();
            rst = tbl[i].rst; ack = tbl[i].ack; ready = tbl[i].ready;
            pc[0] = tbl[i].pc0; pc[1] = tbl[i].pc1;
            waddr[0] = 5'd5; wdata[0] = 64'h1234; gpr[0] = 1'b1;
            cycle();
            chk($sformatf("tbl%0d_valid", i), 64'(trace_valid_o), 64'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_pc", i), trace_pc_o, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_seq", i), 64'(trace_seq_o), 64'(tbl[i].exp_seq));
            chk($sformatf("tbl%0d_af", i), 64'(almost_full_o), 64'(tbl[i].exp_af));
        end
        idle(); rst = 1'b1; cycle(); rst = 1'b0;
        ack = 2'b01; pc[0] = 64'h80000000; waddr[0] = 5'd5; wdata[0] = 64'h1234; gpr[0] = 1'b1;
        cycle();
        chk("single_rd", 64'(trace_rd_o), 64'd5);
        chk("single_wdata", trace_wdata_o, 64'h1234);
        chk("single_gpr", 64'(trace_we_gpr_o), 64'd1);

        // Fill, then drop both requests while a pop happens.
        idle(); rst = 1'b1; cycle(); idle();
        for (int c = 0; c < 4; c++) push(2'b11, 1'b0);
        chk("fill_af", 64'(almost_full_o), 64'd1);
        push(2'b11, 1'b1);
        chk("full_drop_cnt", 64'(drop_cnt_o), 64'd2);
        chk("full_ovf", 64'(overflow_o), 64'd1);
        chk("full_pop_seq", 64'(trace_seq_o), 64'd1);
        push(2'b01, 1'b0);
        idle();
        for (int c = 0; c < 7; c++) begin ready = 1'b1; cycle(); end
        chk("gap_seq", 64'(trace_seq_o), 64'd10);
        chk("gap_valid", 64'(trace_valid_o), 64'd1);

        // Trap records.
        idle(); rst = 1'b1; cycle(); idle();
        exv = 1'b1; cause = 64'h2; expc = 64'h200; cycle();
        chk("trap_ex", 64'(trace_ex_o), 64'd1);
        chk("trap_wdata", trace_wdata_o, 64'h2);
        chk("trap_pc", trace_pc_o, 64'h200);
        chk("trap_we", 64'({trace_we_gpr_o, trace_we_fpr_o}), 64'd0);
        exv = 1'b1; cause = 64'h7; expc = 64'h300; push(2'b11, 1'b1);
        chk("trap3_drop", 64'(drop_cnt_o), 64'd1);
        chk("trap3_seq", 64'(trace_seq_o), 64'd1);

        // Saturation and clear.
        idle(); rst = 1'b1; cycle(); idle();
        for (int c = 0; c < 4; c++) push(2'b11, 1'b0);
        exv = 1'b1;
        for (int c = 0; c < 21845; c++) push(2'b11, 1'b0);
        chk("sat_full", 64'(drop_cnt_o), 64'hFFFF);
        push(2'b11, 1'b0);
        chk("sat_hold", 64'(drop_cnt_o), 64'hFFFF);
        idle(); clr = 1'b1; push(2'b01, 1'b0);
        chk("clr_drop_cnt", 64'(drop_cnt_o), 64'd1);
        chk("clr_drop_ovf", 64'(overflow_o), 64'd1);
        idle(); clr = 1'b1; cycle();
        chk("clr_cnt", 64'(drop_cnt_o), 64'd0);
        chk("clr_ovf", 64'(overflow_o), 64'd0);

        // Reset with five entries queued and traffic in the reset cycle.
        idle(); rst = 1'b1; cycle(); idle();
        push(2'b11, 1'b0); push(2'b11, 1'b0); push(2'b01, 1'b0);
        rst = 1'b1; push(2'b11, 1'b1); rst = 1'b0;
        chk("rst_valid", 64'(trace_valid_o), 64'd0);
        chk("rst_af", 64'(almost_full_o), 64'd0);
        idle(); push(2'b01, 1'b0);
        chk("rst_seq", 64'(trace_seq_o), 64'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst = ($urandom_range(0, 199) == 0);
            clr = ($urandom_range(0, 29) == 0);
            exv = ($urandom_range(0, 5) == 0);
            cause = {$urandom, $urandom}; expc = {$urandom, $urandom};
            push(2'($urandom), ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
